// File: rtl/reflet_inst_loader.sv
// reflet_inst_loader: owns the single port of the 16-bit instruction RAM.
// In IDLE, CPU accesses pass straight through to the RAM. A start request
// holds the CPU in reset and receives a length-prefixed byte image. The image
// is packed into little-endian 16-bit words and written from address 0 upward.
// When the image is complete, the CPU is released.
// Optional feature macro: REFLET_LOADER_CHECKSUM_EN. When defined, a trailing
// checksum byte must make the 8-bit sum of all data bytes wrap to zero.
// Stream handshake: a byte moves on a rising edge where rx_valid & rx_ready
// are both high. rx_ready depends only on the current state, never on rx_valid.
module reflet_inst_loader #(
  parameter int unsigned size = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        cpu_enable,
  input  logic        cpu_write_en,
  input  logic [14:0] cpu_addr,
  input  logic [15:0] cpu_data_in,
  output logic [15:0] cpu_data_out,
  output logic        ram_enable,
  output logic        ram_write_en,
  output logic [14:0] ram_addr,
  output logic [15:0] ram_data_in,
  input  logic [15:0] ram_data_out,
  output logic        cpu_reset_n,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LEN_LO  = 4'd1,
    LEN_HI  = 4'd2,
    CHK_LEN = 4'd3,
    DATA_LO = 4'd4,
    DATA_HI = 4'd5,
    WRITE   = 4'd6,
`ifdef REFLET_LOADER_CHECKSUM_EN
    CKSUM   = 4'd7,
`endif
    DONE    = 4'd8,
    ERROR   = 4'd9
  } state_t;

  localparam logic [15:0] SIZE_W = 16'(size);

  // State that follows the last data byte (or an empty image).
`ifdef REFLET_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CKSUM;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t      state_q, state_d;
  logic        hold_q, hold_d;     // high keeps the CPU in reset
  logic        error_q, error_d;
  logic [14:0] ptr_q, ptr_d;       // byte address of the next word, always even
  logic [15:0] rem_q, rem_d;       // image length, then bytes still to receive
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
`ifdef REFLET_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif
  logic        xfer;

  // Handshake and status decode from the current state only.
  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      LEN_LO, LEN_HI, DATA_LO, DATA_HI: rx_ready = 1'b1;
`ifdef REFLET_LOADER_CHECKSUM_EN
      CKSUM: rx_ready = 1'b1;
`endif
      default: rx_ready = 1'b0;
    endcase
    xfer        = rx_valid & rx_ready;
    busy        = (state_q != IDLE) && (state_q != ERROR);
    done        = (state_q == DONE);
    error       = error_q;
    cpu_reset_n = reset & ~hold_q;
    state_dbg   = state_q;
  end

  // RAM port ownership: CPU passthrough in IDLE, loader everywhere else.
  always_comb begin
    if (state_q == IDLE) begin
      ram_enable   = cpu_enable;
      ram_write_en = cpu_write_en;
      ram_addr     = cpu_addr;
      ram_data_in  = cpu_data_in;
      cpu_data_out = ram_data_out;
    end else begin
      ram_enable   = (state_q == WRITE);
      ram_write_en = (state_q == WRITE);
      ram_addr     = ptr_q;
      ram_data_in  = {hi_q, lo_q};
      cpu_data_out = 16'h0000;
    end
  end

  // Next-state and datapath updates for the load sequence.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    error_d = error_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
`ifdef REFLET_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE, ERROR: begin
        if (start) begin
          state_d = LEN_LO;
          hold_d  = 1'b1;
          error_d = 1'b0;
          ptr_d   = 15'd0;
`ifdef REFLET_LOADER_CHECKSUM_EN
          sum_d   = 8'h00;
`endif
        end
      end
      LEN_LO: begin
        if (xfer) begin
          rem_d   = {8'h00, rx_data};
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          rem_d   = {rx_data, rem_q[7:0]};
          state_d = CHK_LEN;
        end
      end
      CHK_LEN: begin
        if (rem_q > SIZE_W) begin
          state_d = ERROR;
          error_d = 1'b1;
        end else if (rem_q == 16'd0) begin
          state_d = AFTER_DATA;
        end else begin
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        if (xfer) begin
          lo_d  = rx_data;
          rem_d = rem_q - 16'd1;
`ifdef REFLET_LOADER_CHECKSUM_EN
          sum_d = sum_q + rx_data;
`endif
          // An odd final byte is padded with a zero high byte.
          if (rem_q == 16'd1) begin
            hi_d    = 8'h00;
            state_d = WRITE;
          end else begin
            state_d = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (xfer) begin
          hi_d    = rx_data;
          rem_d   = rem_q - 16'd1;
`ifdef REFLET_LOADER_CHECKSUM_EN
          sum_d   = sum_q + rx_data;
`endif
          state_d = WRITE;
        end
      end
      WRITE: begin
        ptr_d   = ptr_q + 15'd2;
        state_d = (rem_q != 16'd0) ? DATA_LO : AFTER_DATA;
      end
`ifdef REFLET_LOADER_CHECKSUM_EN
      CKSUM: begin
        if (xfer) begin
          if (8'(sum_q + rx_data) == 8'h00) begin
            state_d = DONE;
          end else begin
            state_d = ERROR;
            error_d = 1'b1;
          end
        end
      end
`endif
      DONE: begin
        hold_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any load in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= 1'b0;
      error_q <= 1'b0;
      ptr_q   <= 15'd0;
      rem_q   <= 16'd0;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
`ifdef REFLET_LOADER_CHECKSUM_EN
      sum_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      error_q <= error_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
`ifdef REFLET_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_reflet_inst_loader.sv
// Bench for reflet_inst_loader. It uses a behavioural RAM, a packing reference
// model, and a scoreboard of expected loader writes.
module tb_reflet_inst_loader;
  localparam int SIZE = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        cpu_enable = 1'b0;
  logic        cpu_write_en = 1'b0;
  logic [14:0] cpu_addr = 15'd0;
  logic [15:0] cpu_data_in = 16'h0000;
  logic [15:0] cpu_data_out;
  logic        ram_enable, ram_write_en;
  logic [14:0] ram_addr;
  logic [15:0] ram_data_in, ram_data_out;
  logic        cpu_reset_n, busy, done, error;
  logic [3:0]  state_dbg;

  reflet_inst_loader #(.size(SIZE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cpu_enable(cpu_enable), .cpu_write_en(cpu_write_en),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
    .ram_enable(ram_enable), .ram_write_en(ram_write_en),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .cpu_reset_n(cpu_reset_n), .busy(busy), .done(done), .error(error),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, combinational read
  logic [15:0] mem [0:63];
  logic [15:0] model_mem [0:63];
  initial for (int i = 0; i < 64; i++) begin mem[i] = 16'h0000; model_mem[i] = 16'h0000; end
  always @(posedge clk) if (ram_enable && ram_write_en) mem[ram_addr[6:1]] <= ram_data_in;
  assign ram_data_out = mem[ram_addr[6:1]];

  // Scoreboard state
  int n_checks = 0;
  int n_pass = 0;
  int n_writes = 0;
  int done_cnt = 0;
  bit gaps = 1'b0;
  logic [30:0] exp_q[$];
  logic [7:0]  img_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Loader write monitor: every write while busy must match the scoreboard
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy && ram_enable && ram_write_en) begin
      n_writes++;
      if (exp_q.size() == 0) check("extra_write", 32'(exp_q.size()), 1);
      else check("ram_write", {1'b0, ram_addr, ram_data_in}, {1'b0, exp_q.pop_front()});
    end
  end

  // Driver tasks
  task automatic cpu_write(input logic [14:0] a, input logic [15:0] d);
    @(negedge clk);
    cpu_enable = 1'b1; cpu_write_en = 1'b1; cpu_addr = a; cpu_data_in = d;
    @(negedge clk);
    cpu_enable = 1'b0; cpu_write_en = 1'b0;
    model_mem[a[6:1]] = d;
  endtask

  task automatic cpu_read(input string tag, input logic [14:0] a, input logic [15:0] exp);
    cpu_enable = 1'b1; cpu_write_en = 1'b0; cpu_addr = a;
    #1;
    check(tag, cpu_data_out, exp);
    @(negedge clk);
    cpu_enable = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_cpu_rst", cpu_reset_n, 0);
    check("start_err_clr", error, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    if (gaps) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin rx_data = 8'($urandom); @(negedge clk); end
    end
    rx_data = b; rx_valid = 1'b1; t = 0;
    while (!rx_ready && t < 50) begin @(negedge clk); t++; end
    check("rx_ready", rx_ready, 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Reference model: pack img_q into words at byte addresses 0,2,4...
  task automatic load_image(input int len, input bit corrupt);
    int w0, d0, t;
    bit exp_err;
    logic [7:0] s;
    logic [15:0] w;
    logic [15:0] l16;
    w0 = n_writes; d0 = done_cnt; s = 8'h00; l16 = 16'(len);
    exp_err = (len > SIZE);
`ifdef REFLET_LOADER_CHECKSUM_EN
    exp_err = exp_err || corrupt;
`endif
    if (len <= SIZE) begin
      for (int i = 0; i < len; i += 2) begin
        w = {(i + 1 < len) ? img_q[i+1] : 8'h00, img_q[i]};
        exp_q.push_back({15'(i), w});
        model_mem[i/2] = w;
      end
    end
    do_start();
    send_byte(l16[7:0]);
    send_byte(l16[15:8]);
    if (len <= SIZE) begin
      for (int i = 0; i < len; i++) begin
        send_byte(img_q[i]);
        s = s + img_q[i];
      end
`ifdef REFLET_LOADER_CHECKSUM_EN
      s = 8'(8'h00 - s);
      if (corrupt) s = s + 8'h01;
      send_byte(s);
`endif
    end
    t = 0;
    while (busy && t < 20) begin
      if (done) check("cpu_rst_in_done", cpu_reset_n, 0);
      @(negedge clk);
      t++;
    end
    check("busy_end", busy, 0);
    check("error_end", error, exp_err);
    check("done_pulses", 32'(done_cnt - d0), exp_err ? 0 : 1);
    check("write_count", 32'(n_writes - w0), (len <= SIZE) ? (len + 1) / 2 : 0);
    check("cpu_rst_end", cpu_reset_n, !exp_err);
    check("sb_empty", 32'(exp_q.size()), 0);
    if (!exp_err)
      for (int i = 0; i < len; i += 2) cpu_read("readback", 15'(i), model_mem[i/2]);
  endtask

  task automatic fill_random(input int len);
    img_q.delete();
    for (int i = 0; i < len; i++) img_q.push_back(8'($urandom));
  endtask

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Main sequence
  initial begin
    int lens[4];
    repeat (3) @(negedge clk);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_cpu_rst", cpu_reset_n, 0);
    check("rst_ram_we", ram_write_en, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_cpu_rst", cpu_reset_n, 1);

    // CPU passthrough
    cpu_write(15'd4, 16'h1234);
    cpu_read("cpu_rd4", 15'd4, 16'h1234);
    check("idle_busy", busy, 0);

    // Fixed even image
    img_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    load_image(4, 1'b0);
    cpu_read("fix_w0", 15'd0, 16'hBBAA);
    cpu_read("fix_w2", 15'd2, 16'hDDCC);
    cpu_read("fix_w4_kept", 15'd4, 16'h1234);

    // Fixed odd image
    img_q = {8'h11, 8'h22, 8'h33};
    load_image(3, 1'b0);
    cpu_read("odd_w0", 15'd0, 16'h2211);
    cpu_read("odd_w2", 15'd2, 16'h0033);

    // Oversized length; the next load clears error
    load_image(SIZE + 1, 1'b0);
    check("err_state_ram_en", ram_enable, 0);

`ifdef REFLET_LOADER_CHECKSUM_EN
    fill_random(6);
    load_image(6, 1'b1);
    gaps = 1'b1;
    fill_random(6);
    load_image(6, 1'b1);
    gaps = 1'b0;
`endif

    // Boundary and random lengths with random valid gaps
    gaps = 1'b1;
    lens = '{0, 1, SIZE, 2};
    foreach (lens[k]) begin fill_random(lens[k]); load_image(lens[k], 1'b0); end
    for (int k = 0; k < 4; k++) begin
      int l;
      l = $urandom_range(1, SIZE);
      fill_random(l);
      load_image(l, 1'b0);
    end
    gaps = 1'b0;

    // Reset asserted while waiting in DATA_HI
    do_start();
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'h5A);
    cpu_enable = 1'b1; cpu_write_en = 1'b0; cpu_addr = 15'd4;
    #1;
    check("load_cpu_out", cpu_data_out, 0);
    check("load_ram_en", ram_enable, 0);
    cpu_enable = 1'b0;
    reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_rx_ready", rx_ready, 0);
    check("arst_cpu_rst", cpu_reset_n, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_cpu_rst", cpu_reset_n, 1);
    cpu_write(15'd6, 16'hBEEF);
    cpu_read("post_rst_rd", 15'd6, 16'hBEEF);
    check("final_sb_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
